pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline. It takes the hazard indications from the ID-stage forwarding unit (Load-Use), the EX-stage jump/branch resolution and the MEM-stage bus handshake. It generates per-stage hold and bubble controls. It also produces the one-cycle `suspend_finish` strobe that the forwarding unit consumes when a memory-induced suspension ends. A wait-cycle watchdog and a saturating stall-cycle counter support bus debugging.

## Interface
- `TIMEOUT`, 16: max cycles spent in WAIT before declaring a bus error; legal range 2..65535.
- `CNT_W`, 16: width of the stall-cycle performance counter.

- `cpu_clk`  in  1  clock; all state updates on rising edge.
- `cpu_rst`  in  1  reset, asynchronous, active-high.
- `load_use`  in  1  Load-Use hazard detected between ID and EX.
- `ex_jump`  in  1  EX has resolved a taken branch/jump; IF and ID hold wrong-path instructions.
- `mem_req`  in  1  MEM stage holds a valid load/store.
- `mem_ack`  in  1  bus completes the MEM access this cycle.
- `pc_stall`  out  1  hold PC.
- `if_id_stall`, `id_ex_stall`, `ex_mem_stall`, `mem_wb_stall`  out  1 each  hold the corresponding pipeline register.
- `if_id_flush`, `id_ex_flush`  out  1 each  load a bubble into the corresponding pipeline register.
- `suspend_finish`  out  1  registered one-cycle pulse; the memory suspension has ended.
- `bus_err`  out  1  sticky; the watchdog expired.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `pc_stall`=1.

## Operation
- FSM states:
  - IDLE, reset state.
  - WAIT, memory access outstanding.
  - ERR, watchdog expired; terminal until reset.
- Transitions:
  - IDLE→WAIT when `mem_req & ~mem_ack`.
  - WAIT→IDLE when `mem_ack`.
  - WAIT→ERR when `~mem_ack` and `wait_cnt == TIMEOUT-1`.
  - ERR→ERR always.
- `wait_cnt` is a clog2(TIMEOUT)-bit counter:
  - cleared in IDLE;
  - increments by 1 each cycle in WAIT without ack.
- `suspend` (combinational) = `(state==IDLE & mem_req & ~mem_ack) | (state==WAIT & ~mem_ack) | state==ERR`.
- Output priority, highest first:
  1. `suspend`: all five stalls = 1; both flushes = 0. `ex_jump` and `load_use` are ignored; they stay asserted by the frozen stages and are re-evaluated afterwards.
  2. `ex_jump`: `if_id_flush` = `id_ex_flush` = 1; all stalls = 0. `load_use` is ignored because the ID instruction is wrong-path.
  3. `load_use`: `pc_stall` = `if_id_stall` = 1; `id_ex_flush` = 1; other stalls = 0.
  4. Otherwise all stall and flush outputs = 0.
- `suspend_finish` register:
  - set when `state==WAIT & mem_ack`;
  - otherwise 0.
- `bus_err` register is set on the WAIT→ERR transition and never cleared except by reset.
- `stall_cnt` increments by 1 on every cycle with `pc_stall`=1 and holds at 2^CNT_W−1.
- `mem_req` deasserted while in WAIT is a protocol violation. The FSM does not check it and keeps waiting for `mem_ack`.

## Timing
- Reset values while `cpu_rst`=1:
  - state = IDLE, `wait_cnt` = 0, `suspend_finish` = 0, `bus_err` = 0, `stall_cnt` = 0.
  - All stall and flush outputs are forced to 0 regardless of the other inputs.
- Reset asserted mid-WAIT or in ERR returns to IDLE asynchronously. No `suspend_finish` pulse is produced.
- Stall and flush outputs are combinational from the inputs and state, valid in the same cycle.
- `mem_req & mem_ack` in the same cycle in IDLE is a zero-wait access: no stall, no state change, no `suspend_finish`.
- Access acked N≥1 cycles after `mem_req`:
  - stalls are high for exactly N cycles (the request cycle through the cycle before ack);
  - stalls are 0 in the ack cycle;
  - `suspend_finish` is high for exactly the one cycle after ack.
- Back-to-back: if a new `mem_req & ~mem_ack` arrives in the cycle `suspend_finish` is high, the FSM re-enters WAIT from IDLE and `suspend_finish` is still high that cycle.
- Watchdog timing: with no ack, ERR is entered at the edge ending the TIMEOUT-th WAIT cycle. `bus_err` becomes visible the next cycle. Stalls stay high forever.

## Test plan
- Reset: assert `cpu_rst` with `load_use`=`ex_jump`=`mem_req`=1 → all outputs 0. Release with all inputs 0 → all outputs stay 0.
- Load-Use: single-cycle `load_use`=1 → `pc_stall`=`if_id_stall`=`id_ex_flush`=1, others 0; next cycle all 0; `stall_cnt`=1.
- Jump beats Load-Use: `ex_jump`=`load_use`=1 → `if_id_flush`=`id_ex_flush`=1, all stalls 0, `stall_cnt` unchanged.
- 3-wait access: `mem_req`=1 for 4 cycles, `mem_ack`=1 in cycle 4, `ex_jump`=1 throughout:
  - cycles 1–3: all stalls 1, flushes 0;
  - cycle 4: flushes 1;
  - cycle 5: `suspend_finish`=1 for one cycle;
  - final `stall_cnt`=3.
- Zero-wait: `mem_req`=`mem_ack`=1 for 5 cycles → no stall, `suspend_finish` never 1.
- Watchdog with `TIMEOUT`=4: `mem_req`=1, `mem_ack` never → `bus_err`=1 from cycle 6 on, stalls stay 1; a late `mem_ack` does not clear them; `cpu_rst` clears everything.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and per-stage hold/bubble controls exchanged between the
// pipeline datapath (master) and the stall/flush controller (slave).
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             load_use;
    logic             ex_jump;
    logic             mem_req;
    logic             mem_ack;
    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             ex_mem_stall;
    logic             mem_wb_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             suspend_finish;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output load_use, ex_jump, mem_req, mem_ack,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
        input  if_id_flush, id_ex_flush, suspend_finish, bus_err, stall_cnt
    );

    modport slave (
        input  load_use, ex_jump, mem_req, mem_ack,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
        output if_id_flush, id_ex_flush, suspend_finish, bus_err, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: memory suspension FSM with watchdog,
// jump and Load-Use hazard resolution, and a saturating stall counter.
module pipeline_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    pipeline_ctrl_if.slave ctl
);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              suspend;
    logic              wait_expired;
    logic              pc_stall;
    logic              if_id_stall;
    logic              id_ex_stall;
    logic              ex_mem_stall;
    logic              mem_wb_stall;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              suspend_finish;
    logic              bus_err;
    logic [CNT_W-1:0]  stall_cnt;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        next_state   = state;
        suspend      = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ctl.mem_req && !ctl.mem_ack) begin
                    next_state = ST_WAIT;
                    suspend    = 1'b1;
                end
            end
            ST_WAIT: begin
                if (ctl.mem_ack) begin
                    next_state = ST_IDLE;
                end else begin
                    suspend = 1'b1;
                    if (wait_expired) begin
                        next_state = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                suspend = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // A suspension freezes every stage; jump and Load-Use stay asserted
        // by the frozen stages and are resolved once the bus releases.
        if (!cpu_rst) begin
            if (suspend) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_stall = 1'b1;
            end else if (ctl.ex_jump) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (ctl.load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            wait_cnt       <= '0;
            suspend_finish <= 1'b0;
            bus_err        <= 1'b0;
            stall_cnt      <= '0;
        end else begin
            if (state == ST_IDLE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT && !ctl.mem_ack) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            suspend_finish <= (state == ST_WAIT) && ctl.mem_ack;

            if (state == ST_WAIT && next_state == ST_ERR) begin
                bus_err <= 1'b1;
            end

            if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign ctl.pc_stall       = pc_stall;
    assign ctl.if_id_stall    = if_id_stall;
    assign ctl.id_ex_stall    = id_ex_stall;
    assign ctl.ex_mem_stall   = ex_mem_stall;
    assign ctl.mem_wb_stall   = mem_wb_stall;
    assign ctl.if_id_flush    = if_id_flush;
    assign ctl.id_ex_flush    = id_ex_flush;
    assign ctl.suspend_finish = suspend_finish;
    assign ctl.bus_err        = bus_err;
    assign ctl.stall_cnt      = stall_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int VW      = 9 + CNT_W;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    bit m_pending;
    bit m_err;
    bit m_finish;
    int m_waited;
    int m_cnt;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) ctl_if ();

    pipeline_ctrl #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .cpu_clk(cpu_clk),
        .cpu_rst(cpu_rst),
        .ctl    (ctl_if)
    );

    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    // Control vector order: pc, if_id, id_ex, ex_mem, mem_wb stalls, if_id, id_ex flushes.
    function automatic logic [6:0] obs_ctl();
        return {ctl_if.pc_stall, ctl_if.if_id_stall, ctl_if.id_ex_stall,
                ctl_if.ex_mem_stall, ctl_if.mem_wb_stall,
                ctl_if.if_id_flush, ctl_if.id_ex_flush};
    endfunction

    function automatic logic [VW-1:0] observe();
        return {obs_ctl(), ctl_if.suspend_finish, ctl_if.bus_err, ctl_if.stall_cnt};
    endfunction

    function automatic logic [VW-1:0] model_expect();
        logic [6:0] c;
        bit         frozen;
        c = '0;
        if (cpu_rst !== 1'b1) begin
            frozen = m_err || (!ctl_if.mem_ack && (m_pending || ctl_if.mem_req));
            if (frozen)                c = 7'b1111100;
            else if (ctl_if.ex_jump)   c = 7'b0000011;
            else if (ctl_if.load_use)  c = 7'b1100001;
        end
        return {c, m_finish, m_err, CNT_W'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_pending = 0;
        m_err     = 0;
        m_finish  = 0;
        m_waited  = 0;
        m_cnt     = 0;
    endtask

    task automatic drive(input bit lu, input bit ej, input bit rq, input bit ak);
        ctl_if.load_use = lu;
        ctl_if.ex_jump  = ej;
        ctl_if.mem_req  = rq;
        ctl_if.mem_ack  = ak;
    endtask

    task automatic tick();
        logic [VW-1:0] e;
        bit            rq;
        bit            ak;
        e  = model_expect();
        rq = ctl_if.mem_req;
        ak = ctl_if.mem_ack;
        @(posedge cpu_clk);
        if (e[VW-1]) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        m_finish = 0;
        if (!m_err) begin
            if (m_pending) begin
                if (ak) begin
                    m_pending = 0;
                    m_finish  = 1;
                end else begin
                    m_waited++;
                    if (m_waited == TIMEOUT) m_err = 1;
                end
            end else if (rq && !ak) begin
                m_pending = 1;
                m_waited  = 0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0);
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        #2;
        cpu_rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        logic [VW-1:0] obs;
        drive(1, 1, 1, 0);
        cpu_rst = 1'b1;
        #12;
        obs = observe();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_active got %h want %h", obs, {VW{1'b0}});
        end
        drive(0, 0, 0, 0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        model_reset();
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge cpu_clk);
            obs = observe();
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("[TB] FAIL reset_release cyc %0d got %h want %h", k, obs, {VW{1'b0}});
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        logic [VW-1:0] obs;
        drive(1, 0, 0, 0);
        @(negedge cpu_clk);
        checks++;
        if (obs_ctl() !== 7'b1100001) begin
            errors++;
            $display("[TB] FAIL load_use_ctl got %b want %b", obs_ctl(), 7'b1100001);
        end
        tick();
        drive(0, 0, 0, 0);
        @(negedge cpu_clk);
        obs = observe();
        checks++;
        if (obs !== {7'b0, 2'b00, CNT_W'(1)}) begin
            errors++;
            $display("[TB] FAIL load_use_after got %h want %h", obs, {7'b0, 2'b00, CNT_W'(1)});
        end
        tick();
    endtask

    task automatic test_jump_beats_load_use();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        drive(1, 1, 0, 0);
        @(negedge cpu_clk);
        checks++;
        if (obs_ctl() !== 7'b0000011) begin
            errors++;
            $display("[TB] FAIL jump_ctl got %b want %b", obs_ctl(), 7'b0000011);
        end
        tick();
        drive(0, 0, 0, 0);
        @(negedge cpu_clk);
        obs = observe();
        exp = model_expect();
        checks++;
        if (obs[CNT_W-1:0] !== CNT_W'(1) || obs !== exp) begin
            errors++;
            $display("[TB] FAIL jump_cnt got %h want %h", obs, exp);
        end
        tick();
    endtask

    task automatic test_three_wait();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        int            cnt0;
        cnt0 = m_cnt;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 3)      drive(0, 1, 1, 0);
            else if (k == 4) drive(0, 1, 1, 1);
            else             drive(0, 0, 0, 0);
            @(negedge cpu_clk);
            obs = observe();
            exp = model_expect();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL three_wait_model cyc %0d got %h want %h", k, obs, exp);
            end
            checks++;
            if (k <= 3 && obs_ctl() !== 7'b1111100) begin
                errors++;
                $display("[TB] FAIL three_wait_stall cyc %0d got %b want %b", k, obs_ctl(), 7'b1111100);
            end else if (k == 4 && (obs_ctl() !== 7'b0000011 || ctl_if.suspend_finish !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL three_wait_ack got %b/%b want 0000011/0", obs_ctl(), ctl_if.suspend_finish);
            end else if (k == 5 && (ctl_if.suspend_finish !== 1'b1 || ctl_if.stall_cnt !== CNT_W'(cnt0 + 3))) begin
                errors++;
                $display("[TB] FAIL three_wait_finish got %b/%0d want 1/%0d", ctl_if.suspend_finish, ctl_if.stall_cnt, cnt0 + 3);
            end else if (k == 6 && ctl_if.suspend_finish !== 1'b0) begin
                errors++;
                $display("[TB] FAIL three_wait_pulse got %b want 0", ctl_if.suspend_finish);
            end
            tick();
        end
    endtask

    task automatic test_zero_wait();
        for (int k = 0; k < 6; k++) begin
            if (k < 5) drive(0, 0, 1, 1);
            else       drive(0, 0, 0, 0);
            @(negedge cpu_clk);
            checks++;
            if (obs_ctl() !== 7'b0 || ctl_if.suspend_finish !== 1'b0) begin
                errors++;
                $display("[TB] FAIL zero_wait cyc %0d got %b/%b want 0000000/0", k, obs_ctl(), ctl_if.suspend_finish);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        for (int k = 1; k <= 6; k++) begin
            case (k)
                2, 5:    drive(0, 0, 1, 1);
                6:       drive(0, 0, 0, 0);
                default: drive(0, 0, 1, 0);
            endcase
            @(negedge cpu_clk);
            obs = observe();
            exp = model_expect();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL back_to_back cyc %0d got %h want %h", k, obs, exp);
            end
            if (k == 3) begin
                checks++;
                if (ctl_if.suspend_finish !== 1'b1 || obs_ctl() !== 7'b1111100) begin
                    errors++;
                    $display("[TB] FAIL back_to_back_reenter got %b/%b want 1/1111100", ctl_if.suspend_finish, obs_ctl());
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [VW-1:0] obs;
        drive(1, 1, 1, 0);
        tick();
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        #1;
        obs = observe();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_wait got %h want %h", obs, {VW{1'b0}});
        end
        drive(0, 0, 0, 0);
        #1;
        cpu_rst = 1'b0;
        model_reset();
        tick();
        @(negedge cpu_clk);
        obs = observe();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_no_finish got %h want %h", obs, {VW{1'b0}});
        end
        tick();
    endtask

    task automatic test_random();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        bit            rq;
        bit            ak;
        for (int k = 0; k < 400; k++) begin
            rq = m_pending ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (m_pending && m_waited >= TIMEOUT - 2) ak = 1'b1;
            else                                      ak = ($urandom_range(0, 4) < 2);
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), rq, ak);
            @(negedge cpu_clk);
            obs = observe();
            exp = model_expect();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL random cyc %0d got %h want %h", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        for (int k = 0; k < CNT_MAX + 5; k++) begin
            drive(1, 0, 0, 0);
            @(negedge cpu_clk);
            obs = observe();
            exp = model_expect();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL saturation cyc %0d got %h want %h", k, obs, exp);
            end
            tick();
        end
        drive(0, 0, 0, 0);
        @(negedge cpu_clk);
        checks++;
        if (ctl_if.stall_cnt !== CNT_W'(CNT_MAX)) begin
            errors++;
            $display("[TB] FAIL saturation_hold got %0d want %0d", ctl_if.stall_cnt, CNT_MAX);
        end
        tick();
    endtask

    task automatic test_watchdog();
        logic [VW-1:0] obs;
        for (int k = 1; k <= 11; k++) begin
            drive(0, 1, 1, (k > 8));
            @(negedge cpu_clk);
            checks++;
            if (ctl_if.bus_err !== (k >= 6) || obs_ctl() !== 7'b1111100 || ctl_if.suspend_finish !== 1'b0) begin
                errors++;
                $display("[TB] FAIL watchdog cyc %0d got err=%b ctl=%b fin=%b want err=%b ctl=1111100 fin=0",
                         k, ctl_if.bus_err, obs_ctl(), ctl_if.suspend_finish, (k >= 6));
            end
            tick();
        end
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        #1;
        obs = observe();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL watchdog_reset got %h want %h", obs, {VW{1'b0}});
        end
        drive(0, 0, 0, 0);
        #1;
        cpu_rst = 1'b0;
        model_reset();
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_jump_beats_load_use();
        test_three_wait();
        test_zero_wait();
        test_back_to_back();
        test_reset_mid_wait();
        apply_reset();
        test_random();
        test_saturation();
        apply_reset();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
